// File: rtl/sram22_req_ctrl_if.sv
// Request/response bundle between a client and the SRAM22 front-end.
// master = client side, slave = controller side.
interface sram22_req_ctrl_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 10,
    parameter int WMASK_WIDTH = 4
);
    logic                   req_valid;
    logic                   req_ready;
    logic                   req_we;
    logic [WMASK_WIDTH-1:0] req_wmask;
    logic [ADDR_WIDTH-1:0]  req_addr;
    logic [DATA_WIDTH-1:0]  req_wdata;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [DATA_WIDTH-1:0]  rsp_rdata;

    modport master (
        output req_valid, req_we, req_wmask, req_addr, req_wdata,
        output rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_wmask, req_addr, req_wdata,
        input  rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/sram22_req_ctrl.sv
// SRAM22 request front-end: valid/ready requests to single-cycle macro
// accesses, read data buffered in a credit-protected response FIFO.
module sram22_req_ctrl #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 10,
    parameter int WMASK_WIDTH = 4,
    parameter int RSP_DEPTH   = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    sram22_req_ctrl_if.slave       bus,
    output logic                   sram_we,
    output logic [WMASK_WIDTH-1:0] sram_wmask,
    output logic [ADDR_WIDTH-1:0]  sram_addr,
    output logic [DATA_WIDTH-1:0]  sram_din,
    input  logic [DATA_WIDTH-1:0]  sram_dout
);
    localparam int PW = $clog2(RSP_DEPTH);
    localparam int CW = $clog2(RSP_DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(RSP_DEPTH - 1);

    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic                  inflight;
    logic [CW:0]           used;
    logic                  req_fire;
    logic                  write_fire;
    logic                  read_fire;
    logic                  push;
    logic                  pop;
    logic                  valid;
    logic [DATA_WIDTH-1:0] mem [RSP_DEPTH];

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    // Every accepted read owns a FIFO slot from acceptance until pop,
    // so the in-flight read counts against the credit limit.
    assign used       = {1'b0, count} + (CW + 1)'(inflight);
    assign bus.req_ready = !rst && (used < (CW + 1)'(RSP_DEPTH));
    assign req_fire   = bus.req_valid && bus.req_ready;
    assign write_fire = req_fire && bus.req_we;
    assign read_fire  = req_fire && !bus.req_we;

    assign sram_we    = write_fire;
    assign sram_wmask = write_fire ? bus.req_wmask : '0;
    assign sram_addr  = bus.req_addr;
    assign sram_din   = bus.req_wdata;

    // Macro dout is valid the cycle after the read edge: push then.
    assign push  = inflight;
    assign valid = !rst && (count != '0);
    assign pop   = valid && bus.rsp_ready;

    assign bus.rsp_valid = valid;
    assign bus.rsp_rdata = mem[rd_ptr];

    // Pointers, occupancy and in-flight flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= read_fire;
            if (push) wr_ptr <= bump(wr_ptr);
            if (pop)  rd_ptr <= bump(rd_ptr);
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Capture read data into the FIFO storage.
    always_ff @(posedge clk) begin
        if (!rst && push) mem[wr_ptr] <= sram_dout;
    end

    a_no_overflow: assert property (
        @(posedge clk) disable iff (rst)
        !(push && !pop && count == CW'(RSP_DEPTH))
    );
endmodule
